mips_multicycle_controller: RTL and testbench
=============================================

Name: mips_multicycle_controller

Overview:
- Moore-style control FSM for the 8-bit multicycle MIPS datapath.
- Consumes the `op`, `funct` and `zero` outputs of the datapath.
- Drives every datapath control input, plus memory read/write strobes.
- Sequences byte-wise instruction fetch, decode, execute, memory and writeback for LB, SB, R-type, BEQ, J and ADDI.

Parameters:
- None. Opcode, funct and ALU-control encodings are package constants.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- op  input  6  instruction opcode from datapath
- funct  input  6  R-type function field from datapath
- zero  input  1  combinational ALU zero flag from datapath
- pcen  output  1  PC register enable
- iord  output  1  memory address select: 0 = PC, 1 = ALU result
- irwrite  output  4  one-hot instruction-register byte write enable
- regdst  output  1  write-register select: 0 = rt, 1 = rd
- memtoreg  output  1  writeback select: 0 = ALU, 1 = memory data
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A select: 0 = PC, 1 = reg A
- alusrcb  output  2  ALU B select: 00 = B, 01 = 1, 10 = imm, 11 = imm<<2
- alucont  output  3  ALU operation
- pcsource  output  2  next-PC select: 00 = ALU, 01 = ALUOUT flop, 10 = jump target
- memread  output  1  memory read strobe
- memwrite  output  1  memory write strobe
- illegal  output  1  illegal-opcode flag (constant 0 unless the optional feature is enabled)

Behaviour:
- State register resets asynchronously to FETCH1 while reset = 0.
- While reset = 0, every output is forced to 0, including pcen and irwrite.
- Outputs are decoded from the state only. The exception is pcen in BEQEX, which equals zero.
- pcen = pcwrite | (pcwritecond & zero).
- ALU codes: add = 010, sub = 110, and = 000, or = 001, slt = 111.
- States, non-zero outputs and transitions:
  - FETCH1..FETCH4: memread = 1, iord = 0, irwrite = 0001/0010/0100/1000, alusrca = 0, alusrcb = 01, alucont = add, pcsource = 00, pcen = 1. PC advances by 1 per byte. Transitions FETCH1 → FETCH2 → FETCH3 → FETCH4 → DECODE.
  - DECODE: alusrca = 0, alusrcb = 11, alucont = add; precomputes the branch target into the ALUOUT flop. Next state by op:
    - 100000 → MEMADR (LB)
    - 101000 → MEMADR (SB)
    - 000000 → RTYPEEX
    - 000100 → BEQEX
    - 000010 → JEX
    - 001000 → ADDIEX
    - any other op → FETCH1 (see Optional Feature)
  - MEMADR: alusrca = 1, alusrcb = 10, alucont = add. Goes to LBRD if op = LB, else SBWR.
  - LBRD: memread = 1, iord = 1 → LBWR.
  - LBWR: regwrite = 1, memtoreg = 1, regdst = 0 → FETCH1.
  - SBWR: memwrite = 1, iord = 1 → FETCH1.
  - RTYPEEX: alusrca = 1, alusrcb = 00, alucont = function of funct → RTYPEWR.
    - funct 100000 → add
    - 100010 → sub
    - 100100 → and
    - 100101 → or
    - 101010 → slt
    - any other funct → add
  - RTYPEWR: regwrite = 1, regdst = 1, memtoreg = 0 → FETCH1.
  - BEQEX: alusrca = 1, alusrcb = 00, alucont = sub, pcsource = 01, pcen = zero → FETCH1.
  - JEX: pcsource = 10, pcen = 1 → FETCH1.
  - ADDIEX: alusrca = 1, alusrcb = 10, alucont = add → ADDIWR.
  - ADDIWR: regwrite = 1, regdst = 0, memtoreg = 0 → FETCH1.
- Instruction latency, in cycles from FETCH1 entry to next FETCH1: LB 8, SB 7, R-type 7, ADDI 7, BEQ 6, J 6.
- Invariants:
  - irwrite is one-hot or zero.
  - memread and memwrite are never both 1.
  - regwrite is never 1 in a FETCH state.
- Reset asserted mid-instruction aborts immediately: no write strobe may remain high, and the FSM restarts at FETCH1 after release.
- First clock edge after reset release executes FETCH1.
- op and funct are sampled only in DECODE, MEMADR and RTYPEEX. The instruction register is stable in those states.

Optional Feature:
- Macro: MIPS_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown op in DECODE transitions to a HALT state.
  - HALT drives all controls to 0 and illegal = 1, and holds until reset.
- Undefined:
  - No HALT state exists and illegal is tied to 0.
  - Unknown op returns to FETCH1 with no architectural side effect.

Decomposition:
- Shared package `mips_pkg`:
  - opcode localparams (OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI)
  - funct localparams
  - ALU-control constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT)
  - state encoding constants
- One sub-module: `alu_decoder`, a combinational map from (aluop[1:0], funct) to alucont.
  - aluop 00 → add
  - aluop 01 → sub
  - aluop 10 → decode funct

Test Plan:
- Hold reset = 0 for 3 cycles, then release → all outputs 0 during reset; first cycle after release shows irwrite = 0001, memread = 1, pcen = 1, alusrcb = 01.
- Feed op = 000000, funct = 100010 → FETCH1–4 then DECODE, then RTYPEEX with alucont = 110 and alusrca = 1, then RTYPEWR with regwrite = 1 and regdst = 1; back in FETCH1 after 7 cycles.
- Feed op = 100000 (LB) → MEMADR with alusrcb = 10, then LBRD with iord = 1 and memread = 1, then LBWR with memtoreg = 1 and regwrite = 1; 8 cycles total. Feed op = 101000 (SB) → memwrite = 1 for exactly one cycle; 7 cycles total.
- Feed op = 000100 with zero = 1 → pcen = 1, pcsource = 01 in BEQEX. Repeat with zero = 0 → pcen = 0. Feed op = 000010 → pcen = 1, pcsource = 10.
- Pull reset low in LBRD (iord = 1) → memread, regwrite and memwrite drop to 0 asynchronously; FSM resumes at FETCH1 after release.
- Feed op = 111111:
  - with MIPS_CTRL_ILLEGAL_TRAP_EN → illegal = 1 and all controls 0, held for 20 or more cycles until reset;
  - without the macro → next state is FETCH1 and illegal = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the 8-bit multicycle MIPS controller: opcodes, funct
// codes, ALU-control codes, ALU-op classes, state encoding and the bundle of
// raw (pre-reset-gating) control signals produced by the FSM.
package mips_pkg;

  // Opcodes understood by the controller
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes seen by the datapath
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU-op classes handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Controller states; S_HALT is only reachable when the illegal-op trap is built in
  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14,
    S_HALT    = 4'd15
  } state_t;

  // Raw per-state controls; alu_en marks states where alucont is meaningful
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic [3:0] irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       alu_en;
    logic [1:0] pcsource;
    logic       memread;
    logic       memwrite;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-control decoder: maps the FSM's ALU-op class and the
// R-type funct field onto the datapath's 3-bit ALU operation code.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucont
);

  // Fixed add/sub for address and branch math; funct decode for R-type
  always_comb begin
    alucont = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucont = ALU_ADD;
      ALUOP_SUB: alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucont = ALU_ADD;
          FN_SUB:  alucont = ALU_SUB;
          FN_AND:  alucont = ALU_AND;
          FN_OR:   alucont = ALU_OR;
          FN_SLT:  alucont = ALU_SLT;
          default: alucont = ALU_ADD;
        endcase
      end
      default: alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore control FSM for the 8-bit multicycle MIPS datapath (LB, SB, R-type,
// BEQ, J, ADDI). Instructions are fetched one byte per cycle over FETCH1..4.
// Optional build macro MIPS_CTRL_ILLEGAL_TRAP_EN: an unknown opcode in DECODE
// parks the FSM in HALT (all controls 0, illegal = 1) until reset; without it
// an unknown opcode simply returns to FETCH1 and illegal is tied low.
// Interface timing: there is no handshake; every output is a per-cycle control
// level derived from the current state (pcen in BEQEX also follows zero), and
// all outputs are forced low combinationally while reset is low.
module mips_multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucont,
  output logic [1:0] pcsource,
  output logic       memread,
  output logic       memwrite,
  output logic       illegal,
  output logic [3:0] dbg_state
);

  state_t     state;
  state_t     next_state;
  ctrl_t      c;
  logic [2:0] dec_alucont;

  alu_decoder u_alu_decoder (
    .aluop   (c.aluop),
    .funct   (funct),
    .alucont (dec_alucont)
  );

  // State register: asynchronous active-low reset back to FETCH1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH1;
    else        state <= next_state;
  end

  // Next-state and raw Moore control decode; all controls default to 0
  always_comb begin
    next_state = state;
    c          = '0;
    case (state)
      S_FETCH1: begin
        c.memread = 1'b1;  c.irwrite = 4'b0001;
        c.alusrcb = 2'b01; c.aluop = ALUOP_ADD; c.alu_en = 1'b1;
        c.pcwrite = 1'b1;
        next_state = S_FETCH2;
      end
      S_FETCH2: begin
        c.memread = 1'b1;  c.irwrite = 4'b0010;
        c.alusrcb = 2'b01; c.aluop = ALUOP_ADD; c.alu_en = 1'b1;
        c.pcwrite = 1'b1;
        next_state = S_FETCH3;
      end
      S_FETCH3: begin
        c.memread = 1'b1;  c.irwrite = 4'b0100;
        c.alusrcb = 2'b01; c.aluop = ALUOP_ADD; c.alu_en = 1'b1;
        c.pcwrite = 1'b1;
        next_state = S_FETCH4;
      end
      S_FETCH4: begin
        c.memread = 1'b1;  c.irwrite = 4'b1000;
        c.alusrcb = 2'b01; c.aluop = ALUOP_ADD; c.alu_en = 1'b1;
        c.pcwrite = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // PC + (imm << 2) lands in ALUOUT ready for a possible BEQ
        c.alusrcb = 2'b11; c.aluop = ALUOP_ADD; c.alu_en = 1'b1;
        case (op)
          OP_LB:    next_state = S_MEMADR;
          OP_SB:    next_state = S_MEMADR;
          OP_RTYPE: next_state = S_RTYPEEX;
          OP_BEQ:   next_state = S_BEQEX;
          OP_J:     next_state = S_JEX;
          OP_ADDI:  next_state = S_ADDIEX;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          default:  next_state = S_HALT;
`else
          default:  next_state = S_FETCH1;
`endif
        endcase
      end
      S_MEMADR: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = ALUOP_ADD; c.alu_en = 1'b1;
        next_state = (op == OP_LB) ? S_LBRD : S_SBWR;
      end
      S_LBRD: begin
        c.memread = 1'b1; c.iord = 1'b1;
        next_state = S_LBWR;
      end
      S_LBWR: begin
        c.regwrite = 1'b1; c.memtoreg = 1'b1;
        next_state = S_FETCH1;
      end
      S_SBWR: begin
        c.memwrite = 1'b1; c.iord = 1'b1;
        next_state = S_FETCH1;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b00; c.aluop = ALUOP_FUNCT; c.alu_en = 1'b1;
        next_state = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        c.regwrite = 1'b1; c.regdst = 1'b1;
        next_state = S_FETCH1;
      end
      S_BEQEX: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b00; c.aluop = ALUOP_SUB; c.alu_en = 1'b1;
        c.pcsource = 2'b01; c.pcwritecond = 1'b1;
        next_state = S_FETCH1;
      end
      S_JEX: begin
        c.pcsource = 2'b10; c.pcwrite = 1'b1;
        next_state = S_FETCH1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = ALUOP_ADD; c.alu_en = 1'b1;
        next_state = S_ADDIWR;
      end
      S_ADDIWR: begin
        c.regwrite = 1'b1;
        next_state = S_FETCH1;
      end
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      S_HALT: begin
        next_state = S_HALT;
      end
`endif
      default: begin
        next_state = S_FETCH1;
      end
    endcase
  end

  // Reset gating: every strobe drops the moment reset goes low
  assign pcen      = reset & (c.pcwrite | (c.pcwritecond & zero));
  assign iord      = reset & c.iord;
  assign irwrite   = reset ? c.irwrite : 4'b0000;
  assign regdst    = reset & c.regdst;
  assign memtoreg  = reset & c.memtoreg;
  assign regwrite  = reset & c.regwrite;
  assign alusrca   = reset & c.alusrca;
  assign alusrcb   = reset ? c.alusrcb : 2'b00;
  assign alucont   = (reset && c.alu_en) ? dec_alucont : 3'b000;
  assign pcsource  = reset ? c.pcsource : 2'b00;
  assign memread   = reset & c.memread;
  assign memwrite  = reset & c.memwrite;
  assign dbg_state = state;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  assign illegal = reset & (state == S_HALT);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Scoreboard bench for mips_multicycle_controller. The driver walks each
// instruction as a list of architectural actions (fetch byte, decode, address
// calc, load, ...) and pushes the control word each action must present; a
// monitor samples the DUT on the falling edge (and right after an async
// reset drop) and compares against the queue.
module tb_mips_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, iord, regdst, memtoreg, regwrite, alusrca;
  logic       memread, memwrite, illegal;
  logic [3:0] irwrite;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] alucont;
  logic [3:0] dbg_state;

  mips_multicycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .pcen      (pcen),
    .iord      (iord),
    .irwrite   (irwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .alucont   (alucont),
    .pcsource  (pcsource),
    .memread   (memread),
    .memwrite  (memwrite),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {
    A_FETCH, A_DECODE, A_ADDR, A_LOAD, A_LOADWB, A_STORE, A_RR, A_RRWB,
    A_BRANCH, A_JUMP, A_IMM, A_IMMWB, A_HALT
  } act_t;

  logic [19:0] exp_q[$];
  logic [19:0] exp_v;
  logic [19:0] act_v;
  int          total = 0;
  int          bad = 0;
  logic        mon_en = 1'b0;
  logic        chk_pulse = 1'b0;

  assign act_v = {pcen, iord, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, alucont, pcsource, memread, memwrite, illegal};

  function automatic logic [19:0] pack(
    input logic pc_en, input logic io_rd, input logic [3:0] irw,
    input logic rdst, input logic m2r, input logic rwr, input logic srca,
    input logic [1:0] srcb, input logic [2:0] alu, input logic [1:0] pcsrc,
    input logic mrd, input logic mwr, input logic ill);
    return {pc_en, io_rd, irw, rdst, m2r, rwr, srca, srcb, alu, pcsrc, mrd, mwr, ill};
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [19:0] action_vec(input act_t a, input int idx,
                                             input logic [5:0] fn, input logic z);
    logic [3:0] onehot;
    onehot = 4'b0001;
    onehot = onehot << idx[1:0];
    case (a)
      A_FETCH:  return pack(1, 0, onehot, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 1, 0, 0);
      A_DECODE: return pack(0, 0, 4'b0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 0, 0);
      A_ADDR:   return pack(0, 0, 4'b0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0);
      A_LOAD:   return pack(0, 1, 4'b0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 1, 0, 0);
      A_LOADWB: return pack(0, 0, 4'b0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0);
      A_STORE:  return pack(0, 1, 4'b0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1, 0);
      A_RR:     return pack(0, 0, 4'b0, 0, 0, 0, 1, 2'b00, rtype_alu(fn), 2'b00, 0, 0, 0);
      A_RRWB:   return pack(0, 0, 4'b0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0);
      A_BRANCH: return pack(z, 0, 4'b0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0, 0, 0);
      A_JUMP:   return pack(1, 0, 4'b0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0, 0, 0);
      A_IMM:    return pack(0, 0, 4'b0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0);
      A_IMMWB:  return pack(0, 0, 4'b0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0);
      A_HALT:   return pack(0, 0, 4'b0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 1);
      default:  return '0;
    endcase
  endfunction

  function automatic bit is_known_op(input logic [5:0] o);
    return (o == 6'b100000) || (o == 6'b101000) || (o == 6'b000000) ||
           (o == 6'b000100) || (o == 6'b000010) || (o == 6'b001000);
  endfunction

  // ---------------- driver tasks ----------------
  // Entered 1 time unit after the edge that enters FETCH1. zmode 0/1 forces
  // zero, 2 randomises it every cycle. stop_at >= 0 returns right after
  // pushing that step, without advancing the clock.
  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn,
                           input int zmode, input int stop_at);
    act_t plan[$];
    for (int k = 0; k < 4; k++) plan.push_back(A_FETCH);
    plan.push_back(A_DECODE);
    case (iop)
      6'b100000: begin plan.push_back(A_ADDR); plan.push_back(A_LOAD); plan.push_back(A_LOADWB); end
      6'b101000: begin plan.push_back(A_ADDR); plan.push_back(A_STORE); end
      6'b000000: begin plan.push_back(A_RR); plan.push_back(A_RRWB); end
      6'b000100: plan.push_back(A_BRANCH);
      6'b000010: plan.push_back(A_JUMP);
      6'b001000: begin plan.push_back(A_IMM); plan.push_back(A_IMMWB); end
      default: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        for (int k = 0; k < 22; k++) plan.push_back(A_HALT);
`endif
      end
    endcase
    op    = iop;
    funct = ifn;
    for (int i = 0; i < plan.size(); i++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      exp_q.push_back(action_vec(plan[i], i, ifn, zero));
      if (i == stop_at) return;
      @(posedge clk); #1;
    end
  endtask

  // Entered mid-cycle after that cycle's falling-edge sample. Checks outputs
  // right after the asynchronous drop, holds reset for `hold` cycles, then
  // releases one time unit after a rising edge so the FSM sits in FETCH1.
  task automatic reset_pulse(input int hold);
    reset = 1'b0;
    op    = 6'($urandom);
    #1;
    exp_q.push_back('0);
    chk_pulse = 1'b1;
    #1;
    chk_pulse = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < hold; k++) begin
      exp_q.push_back('0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always begin
    @(negedge clk or posedge chk_pulse);
    if (mon_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL ctrl_underflow: got %b with no expected word (state %0d) at %0t",
                 act_v, dbg_state, $time);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          bad++;
          $display("FAIL ctrl_word: got %b expected %b (state %0d reset %b) at %0t",
                   act_v, exp_v, dbg_state, reset, $time);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [5:0] rop;
    logic [5:0] rfn;
    logic [5:0] fn_tab [6];
    logic [5:0] op_tab [6];
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
    op_tab = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000};

    reset = 1'b0;
    op    = 6'd0;
    funct = 6'd0;
    zero  = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    // three cycles in reset: every output must be 0
    for (int k = 0; k < 3; k++) begin
      op   = 6'($urandom);
      zero = 1'($urandom_range(0, 1));
      exp_q.push_back('0);
      @(posedge clk); #1;
    end
    reset = 1'b1;

    // directed instructions
    run_instr(6'b000000, 6'b100010, 2, -1);  // R-type sub
    run_instr(6'b100000, 6'h00, 2, -1);      // LB
    run_instr(6'b101000, 6'h00, 2, -1);      // SB
    run_instr(6'b000100, 6'h00, 1, -1);      // BEQ taken
    run_instr(6'b000100, 6'h00, 0, -1);      // BEQ not taken
    run_instr(6'b000010, 6'h00, 2, -1);      // J
    run_instr(6'b001000, 6'h00, 2, -1);      // ADDI
    run_instr(6'b000000, 6'b101010, 2, -1);  // R-type slt
    run_instr(6'b000000, 6'b111111, 2, -1);  // R-type unknown funct

    // LB aborted by reset while in the load-read cycle
    run_instr(6'b100000, 6'h00, 2, 6);
    #5;
    reset_pulse(2);
    run_instr(6'b000000, 6'b100100, 2, -1);  // resumes cleanly

    // unknown opcode
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    run_instr(6'b111111, 6'h00, 2, 26);
    #5;
    reset_pulse(2);
`else
    run_instr(6'b111111, 6'h00, 2, -1);
`endif

    // randomised instruction stream
    for (int n = 0; n < 60; n++) begin
      rfn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 5)];
      rop = op_tab[$urandom_range(0, 5)];
`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) begin
        rop = 6'($urandom);
        while (is_known_op(rop)) rop = 6'($urandom);
      end
`endif
      run_instr(rop, rfn, 2, -1);
    end

    @(negedge clk);
    mon_en = 1'b0;
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
